addr8s_swap_checker: RTL and testbench

Sequential operand-feed and result-check stage wrapped around the combinational 8-bit signed adder. It accepts one operand pair per transaction and drives the adder twice, once as (A,B) and once swapped as (B,A). It compares the two 9-bit sums, retries on mismatch, then presents the result with a fault flag. It sits directly upstream (operand drive) and downstream (sum capture) of the adder, turning the adder's statistical fault resilience into detected, counted faults.

---
 rtl/addr8s_swap_checker.sv | 105 ++++++++++
 tb/tb_addr8s_swap_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/addr8s_swap_checker.sv
// Operand-feed / result-check stage around an 8-bit signed adder: every pair is
// evaluated as (A,B) and (B,A), mismatches are retried, counted and flagged.
module addr8s_swap_checker #(
    parameter int MAX_RETRY = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_a,
    input  logic [7:0]           in_b,
    output logic [7:0]           add_a,
    output logic [7:0]           add_b,
    input  logic [8:0]           add_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8:0]           out_sum,
    output logic                 out_fault,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW:0] MAX_R = MAX_RETRY[RW:0];

    typedef enum logic [1:0] {IDLE, EVAL1, EVAL2, OUT} state_t;

    state_t        state, state_nx;
    logic [7:0]    ra, rb;
    logic [8:0]    s1;
    logic [RW-1:0] retry;
    logic          mismatch;
    logic          retry_ok;

    // The swapped-pass sum is compared live against s1 on the EVAL2 edge.
    assign mismatch = (state == EVAL2) && (add_sum != s1);
    assign retry_ok = {1'b0, retry} < MAX_R;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        add_a     = 8'h00;
        add_b     = 8'h00;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) state_nx = EVAL1;
            end
            EVAL1: begin
                add_a    = ra;
                add_b    = rb;
                state_nx = EVAL2;
            end
            EVAL2: begin
                add_a    = rb;
                add_b    = ra;
                state_nx = (mismatch && retry_ok) ? EVAL1 : OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ra        <= 8'h00;
            rb        <= 8'h00;
            s1        <= 9'h000;
            retry     <= '0;
            out_sum   <= 9'h000;
            out_fault <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (mismatch && (err_cnt != {ERR_CNT_W{1'b1}}))
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra    <= in_a;
                        rb    <= in_b;
                        retry <= '0;
                    end
                end
                EVAL1: s1 <= add_sum;
                EVAL2: begin
                    if (!mismatch) begin
                        out_sum   <= s1;
                        out_fault <= 1'b0;
                    end else if (!retry_ok) begin
                        out_sum   <= s1;
                        out_fault <= 1'b1;
                    end else begin
                        retry <= retry + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_addr8s_swap_checker.sv
// Directed bench: behavioural adder with injectable faults, vector table plus
// hand sequences for backpressure, mid-transaction reset and counter saturation.
module tb_addr8s_swap_checker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_valid2 = 1'b0;
    logic       in_ready, in_ready2;
    logic [7:0] in_a = 8'h00, in_b = 8'h00;
    logic [7:0] add_a, add_b, add_a2, add_b2;
    logic [8:0] add_sum, add_sum2;
    logic       out_valid, out_valid2;
    logic       out_ready = 1'b0;
    logic [8:0] out_sum, out_sum2;
    logic       out_fault, out_fault2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    always #5 clk = ~clk;

    addr8s_swap_checker #(.MAX_RETRY(2), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_fault(out_fault), .err_cnt(err_cnt));

    addr8s_swap_checker #(.MAX_RETRY(0), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .add_a(add_a2), .add_b(add_b2), .add_sum(add_sum2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
        .out_fault(out_fault2), .err_cnt(err_cnt2));

    // Adder model. mode 1: flip bit 3 on the first swapped pass only;
    // mode 2: bit 0 stuck-at-1 whenever add_a carries operand B.
    logic [7:0] cur_a = 8'h00, cur_b = 8'h00;
    logic [1:0] mode = 2'd0;
    int         eval2_seen = 0;
    logic [8:0] sum_ok, sum_ok2;
    logic       is_eval2;

    assign sum_ok   = {add_a[7], add_a} + {add_b[7], add_b};
    assign sum_ok2  = {add_a2[7], add_a2} + {add_b2[7], add_b2};
    assign is_eval2 = (add_a == cur_b) && (add_b == cur_a) && (cur_a != cur_b);
    assign add_sum  = (mode == 2'd1 && is_eval2 && eval2_seen == 0) ? (sum_ok ^ 9'h008) :
                      (mode == 2'd2 && add_a == cur_b && cur_a != cur_b) ? (sum_ok | 9'h001) :
                      sum_ok;
    assign add_sum2 = (add_a2 == cur_b && cur_a != cur_b) ? (sum_ok2 | 9'h001) : sum_ok2;

    always @(posedge clk) begin
        if (in_valid && in_ready) eval2_seen <= 0;
        else if (is_eval2)        eval2_seen <= eval2_seen + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
    endtask

    // Accept a pair on dut, return cycles from accept until out_valid.
    task automatic start_txn(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        in_a = a; in_b = b; cur_a = a; cur_b = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_a = 8'hAA; in_b = 8'h55;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) chk("timeout_out_valid", 32'd0, 32'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic [1:0] md;
        logic [8:0] sum;
        logic       fault;
        logic [7:0] err;
        int         lat;
    } vec_t;

    vec_t vt[8];

    initial begin
        int lat;
        vt[0] = '{8'h7F, 8'h01, 2'd0, 9'h080, 1'b0, 8'd0, 3};
        vt[1] = '{8'h80, 8'h80, 2'd0, 9'h100, 1'b0, 8'd0, 3};
        vt[2] = '{8'hFF, 8'h01, 2'd0, 9'h000, 1'b0, 8'd0, 3};
        vt[3] = '{8'h7F, 8'h7F, 2'd0, 9'h0FE, 1'b0, 8'd0, 3};
        vt[4] = '{8'h80, 8'h7F, 2'd0, 9'h1FF, 1'b0, 8'd0, 3};
        vt[5] = '{8'h00, 8'h00, 2'd0, 9'h000, 1'b0, 8'd0, 3};
        vt[6] = '{8'h10, 8'h05, 2'd1, 9'h015, 1'b0, 8'd1, 5};
        vt[7] = '{8'h02, 8'h04, 2'd2, 9'h006, 1'b1, 8'd3, 7};

        do_reset();
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum",   {23'd0, out_sum},   32'd0);
        chk("rst_out_fault", {31'd0, out_fault}, 32'd0);
        chk("rst_err_cnt",   {24'd0, err_cnt},   32'd0);
        chk("rst_add_ab",    {16'd0, add_a, add_b}, 32'd0);

        foreach (vt[i]) begin
            do_reset();
            mode = vt[i].md;
            start_txn(vt[i].a, vt[i].b, lat);
            chk($sformatf("v%0d_sum", i),   {23'd0, out_sum},   {23'd0, vt[i].sum});
            chk($sformatf("v%0d_fault", i), {31'd0, out_fault}, {31'd0, vt[i].fault});
            chk($sformatf("v%0d_err", i),   {24'd0, err_cnt},   {24'd0, vt[i].err});
            chk($sformatf("v%0d_lat", i),   lat,                vt[i].lat);
            chk($sformatf("v%0d_add_idle", i), {16'd0, add_a, add_b}, 32'd0);
            consume();
        end

        // Backpressure: outputs hold while out_ready is low.
        do_reset();
        mode = 2'd0;
        start_txn(8'h33, 8'h11, lat);
        for (int k = 0; k < 10; k++) begin
            chk("bp_hold", {20'd0, out_valid, in_ready, out_fault, out_sum},
                {20'd0, 1'b1, 1'b0, 1'b0, 9'h044});
            @(negedge clk);
        end
        consume();
        chk("bp_idle", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
        start_txn(8'hF0, 8'hF0, lat);
        chk("bp_second_sum", {23'd0, out_sum}, {23'd0, 9'h1E0});
        chk("bp_second_lat", lat, 3);
        consume();

        // Reset asserted during EVAL2 of a mismatching pair.
        do_reset();
        mode = 2'd2;
        @(negedge clk);
        in_a = 8'h02; in_b = 8'h04; cur_a = 8'h02; cur_b = 8'h04; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mr_in_eval2", {24'd0, add_a}, 32'h04);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_during", {30'd0, out_valid, in_ready}, 32'd0);
        chk("mr_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
        begin
            logic seen = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                seen |= out_valid;
            end
            chk("mr_no_output", {31'd0, seen}, 32'd0);
        end

        // Saturation on a 2-bit counter, one mismatch per transaction.
        do_reset();
        mode = 2'd0;
        for (int k = 1; k <= 5; k++) begin
            int w;
            @(negedge clk);
            in_a = 8'h02; in_b = 8'h04; cur_a = 8'h02; cur_b = 8'h04; in_valid2 = 1'b1;
            @(negedge clk);
            in_valid2 = 1'b0;
            w = 1;
            while (!out_valid2 && w < 40) begin
                @(negedge clk);
                w++;
            end
            chk($sformatf("sat%0d_lat", k), w, 3);
            chk($sformatf("sat%0d_fault", k), {31'd0, out_fault2}, 32'd1);
            chk($sformatf("sat%0d_err", k), {30'd0, err_cnt2}, (k < 3) ? k : 3);
            consume();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
